// File: rtl/mem_bus_pkg.sv
// Shared definitions for the native valid/ready memory bus responder.
//   - FSM state encodings (IDLE, WAIT, ACCESS, RESP) exposed as 2-bit constants
//   - default read data returned for out-of-range addresses
//   - strobe value that marks a request as a read
package mem_bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [31:0] OOR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  localparam logic [3:0]  WSTRB_READ        = 4'h0;

endpackage

// File: rtl/mem_bram_be.sv
// Single-port 32-bit block RAM with four byte-lane write enables.
// Ports:
//   clk   in   clock
//   en    in   access enable for this cycle
//   we    in   [3:0] byte-lane write enables; all zero with en=1 is a read
//   addr  in   [ADDR_WIDTH-1:0] word address
//   wdata in   [31:0] write data
//   rdata out  [31:0] registered read data; updates only on reads
// No reset: contents and the read register power up undefined.
module mem_bram_be #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      // The read register only moves on reads so it keeps the last read word
      // across any number of writes.
      if (we == 4'h0) begin
        rdata <= mem[addr];
      end
      for (int k = 0; k < 4; k++) begin
        if (we[k]) begin
          mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_bram_responder.sv
// Responder side of the valid/ready native memory bus, backed by block RAM.
// Serves single-word reads and byte-strobed writes with WAIT_STATES extra
// cycles before the RAM access.
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   i_valid    in   request; addr/wdata/wstrb held stable until o_ready
//   o_ready    out  one-cycle completion pulse
//   i_addr     in   [31:0] word address
//   i_wdata    in   [31:0] write data
//   i_wstrb    in   [3:0] byte enables, 0 = read
//   o_rdata    out  [31:0] read data, valid in the o_ready cycle of a read
//   o_busy     out  high from capture through the o_ready cycle
//   o_err_cnt  out  [15:0] saturating count of out-of-range accesses
//   o_state    out  [1:0] current FSM state (debug)
// Handshake: a request is taken on the rising edge where the FSM is IDLE and
// i_valid is high; it is then committed regardless of later i_valid or input
// changes, and o_ready pulses for exactly one cycle WAIT_STATES+1 edges after
// the capture edge. The FSM spends at least one cycle in IDLE between
// requests, so a held i_valid is re-sampled only after that idle cycle.
module mem_bus_bram_responder
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] OOR_RDATA   = OOR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic [15:0] o_err_cnt,
  output logic [1:0]  o_state
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  req_oor;
  logic                  rd_seen;
  logic                  rd_oor;
  logic [15:0]           err_cnt;
  logic                  addr_oor;
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;

  // Any address bit at or above ADDR_WIDTH set means the word is not backed.
  assign addr_oor = (i_addr >> ADDR_WIDTH) != 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= WSTRB_READ;
      req_oor   <= 1'b0;
      rd_seen   <= 1'b0;
      rd_oor    <= 1'b0;
      err_cnt   <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            req_addr  <= i_addr[ADDR_WIDTH-1:0];
            req_wdata <= i_wdata;
            req_wstrb <= i_wstrb;
            req_oor   <= addr_oor;
            cnt       <= CNT_LOAD;
            state     <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
          if (req_wstrb == WSTRB_READ) begin
            rd_seen <= 1'b1;
            rd_oor  <= req_oor;
          end
          if (req_oor && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The RAM is touched only in ACCESS, and never for unbacked addresses, so a
  // request aborted by reset before ACCESS leaves memory untouched.
  assign ram_en = (state == ST_ACCESS) && !req_oor;
  assign ram_we = req_wstrb & {4{ram_en}};

  mem_bram_be #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (req_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset, so rd_seen forces zero until the
  // first read after reset completes; rd_oor substitutes the fixed pattern
  // for unbacked reads. Both flags and the RAM register change on the same
  // ACCESS->RESP edge, so the result holds until the next read.
  assign o_rdata   = !rd_seen ? 32'h0000_0000 : (rd_oor ? OOR_RDATA : ram_rdata);
  assign o_ready   = (state == ST_RESP);
  assign o_busy    = (state != ST_IDLE);
  assign o_err_cnt = err_cnt;
  assign o_state   = state;

endmodule

// File: tb/tb_mem_bus_bram_responder.sv
module tb_mem_bus_bram_responder;
  import mem_bus_pkg::*;

  localparam int WS = 2;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic [31:0] o_rdata;
  logic        o_busy;
  logic [15:0] o_err_cnt;
  logic [1:0]  o_state;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_bram_responder #(
    .ADDR_WIDTH  (10),
    .WAIT_STATES (WS),
    .OOR_RDATA   (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_wstrb   (i_wstrb),
    .o_rdata   (o_rdata),
    .o_busy    (o_busy),
    .o_err_cnt (o_err_cnt),
    .o_state   (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request from a point where the DUT is IDLE (#1 after an edge or
  // at time zero after reset release). Checks capture, latency, pulse width
  // and the idle gap; returns o_rdata seen in the o_ready cycle.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit hold, output logic [31:0] rd);
    int n;
    i_valid = 1'b1;
    i_addr  = a;
    i_wdata = d;
    i_wstrb = s;
    @(posedge clk); #1;
    chk("busy_at_capture", {31'd0, o_busy}, 32'd1);
    n  = 0;
    rd = 32'h0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (o_ready) begin
        rd = o_rdata;
        break;
      end
    end
    chk("ready_latency", n, WS + 1);
    if (!hold) i_valid = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'd0, o_ready}, 32'd0);
    chk("idle_gap_busy", {31'd0, o_busy}, 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    // 1: reset holds everything quiet even with a request pending
    rst     = 1'b1;
    i_valid = 1'b1;
    i_addr  = 32'h0;
    i_wdata = 32'h9999_9999;
    i_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_err_cnt", {16'd0, o_err_cnt}, 32'd0);
    chk("rst_state", {30'd0, o_state}, {30'd0, ST_IDLE});
    i_valid = 1'b0;
    rst     = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, o_busy}, 32'd0);

    // 2: full write then read
    do_txn(32'h0, 32'h1111_1111, 4'hF, 1'b0, rd);
    do_txn(32'h0, 32'h0, 4'h0, 1'b0, rd);
    chk("read_full", rd, 32'h1111_1111);

    // 3: partial write only touches lanes 0,1; o_rdata holds across it
    do_txn(32'h0, 32'hAABB_CCDD, 4'b0011, 1'b0, rd);
    chk("rdata_hold_after_write", o_rdata, 32'h1111_1111);
    do_txn(32'h0, 32'h0, 4'h0, 1'b0, rd);
    chk("read_partial", rd, 32'h1111_CCDD);

    // 4: out-of-range read/write
    do_txn(32'h400, 32'h0, 4'h0, 1'b0, rd);
    chk("oor_rdata", rd, 32'hDEAD_BEEF);
    chk("oor_err_cnt1", {16'd0, o_err_cnt}, 32'd1);
    do_txn(32'h400, 32'h1234_5678, 4'hF, 1'b0, rd);
    chk("oor_err_cnt2", {16'd0, o_err_cnt}, 32'd2);
    do_txn(32'h8000_0000, 32'h0, 4'h0, 1'b0, rd);
    chk("oor_high_bit_rdata", rd, 32'hDEAD_BEEF);
    chk("oor_err_cnt3", {16'd0, o_err_cnt}, 32'd3);
    do_txn(32'h0, 32'h0, 4'h0, 1'b0, rd);
    chk("oor_no_alias_write", rd, 32'h1111_CCDD);

    // 5: back-to-back with i_valid held high
    for (int i = 0; i < 16; i++) begin
      do_txn(i, 32'hC0DE_0000 + i + 1, 4'hF, 1'b1, rd);
      do_txn(i, 32'h0, 4'h0, 1'b1, rd);
      chk("b2b_read", rd, 32'hC0DE_0000 + i + 1);
    end
    i_valid = 1'b0;
    chk("b2b_err_cnt_same", {16'd0, o_err_cnt}, 32'd3);

    // 6: reset during WAIT drops the pending write
    do_txn(32'h3, 32'h5555_5555, 4'hF, 1'b0, rd);
    i_valid = 1'b1;
    i_addr  = 32'h3;
    i_wdata = 32'h7777_7777;
    i_wstrb = 4'hF;
    @(posedge clk); #1;
    chk("abort_capture_busy", {31'd0, o_busy}, 32'd1);
    @(posedge clk); #1;
    chk("abort_in_wait", {30'd0, o_state}, {30'd0, ST_WAIT});
    i_valid = 1'b0;
    rst     = 1'b1;
    #1;
    chk("abort_async_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", {31'd0, o_ready}, 32'd0);
    end
    chk("abort_err_cnt_reset", {16'd0, o_err_cnt}, 32'd0);
    do_txn(32'h3, 32'h0, 4'h0, 1'b0, rd);
    chk("abort_write_dropped", rd, 32'h5555_5555);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
